// File: rtl/frame_reply_scheduler.sv
// frame_reply_scheduler: arbitrates parser error replies and AXI completion replies onto one Frame_Builder.
// Optional reply statistics counters are built when REPLY_STATS_EN is defined.
module frame_reply_scheduler #(
  parameter int ERR_QUEUE_DEPTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        err_req,
  input  logic [7:0]  err_status,
  input  logic [7:0]  err_cmd,
  output logic        err_ack,
  input  logic        cmp_req,
  input  logic [7:0]  cmp_status,
  input  logic [7:0]  cmp_cmd,
  output logic        cmp_ack,
  output logic        bld_start,
  output logic [7:0]  bld_status,
  output logic [7:0]  bld_cmd,
  input  logic        bld_done,
  output logic        sched_idle,
  output logic [7:0]  drop_count,
  output logic        timeout_err,
  output logic [15:0] crc_err_count,
  output logic [15:0] reply_count
);
  localparam int AW = $clog2(ERR_QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
  state_t        state;
  logic [15:0]   mem [ERR_QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wd;
  logic [SW-1:0] starve;
  logic          src_cmp, full, empty, finish, pop, push, err_sel, cmp_sel;
  assign full    = count == CW'(ERR_QUEUE_DEPTH);
  assign empty   = count == '0;
  assign finish  = state == WAIT_DONE && (bld_done || wd == WW'(TIMEOUT_CYCLES - 1));
  assign pop     = finish && !src_cmp;
  assign push    = err_req && (!full || pop);
  assign err_sel = state == IDLE && !empty && !(cmp_req && starve == SW'(STARVE_LIMIT));
  // The ack cycle still sees the old cmp_req level, so it must not re-grant.
  assign cmp_sel = state == IDLE && cmp_req && !cmp_ack && !err_sel;
  assign sched_idle = state == IDLE && empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {err_status, err_cmd};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wd          <= '0;
      starve      <= '0;
      src_cmp     <= 1'b0;
      err_ack     <= 1'b0;
      cmp_ack     <= 1'b0;
      bld_start   <= 1'b0;
      bld_status  <= '0;
      bld_cmd     <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      err_ack   <= push;
      cmp_ack   <= finish && src_cmp;
      bld_start <= err_sel || cmp_sel;
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      count     <= count + CW'(push) - CW'(pop);
      if (err_req && !push && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      if (finish && !bld_done) timeout_err <= 1'b1;
      case (state)
        IDLE: if (err_sel || cmp_sel) begin
          state                 <= LAUNCH;
          src_cmp               <= cmp_sel;
          {bld_status, bld_cmd} <= err_sel ? mem[rd_ptr] : {cmp_status, cmp_cmd};
          if (cmp_sel) starve <= '0;
          else if (cmp_req && starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
        end
        LAUNCH: begin
          state <= WAIT_DONE;
          wd    <= '0;
        end
        WAIT_DONE: if (finish) state <= IDLE; else wd <= wd + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef REPLY_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reply_count   <= '0;
      crc_err_count <= '0;
    end else if (bld_start) begin
      if (reply_count != 16'hFFFF) reply_count <= reply_count + 1'b1;
      if (bld_status == 8'h01 && crc_err_count != 16'hFFFF) crc_err_count <= crc_err_count + 1'b1;
    end
  end
`else
  assign reply_count   = '0;
  assign crc_err_count = '0;
`endif
endmodule

// File: tb/tb_frame_reply_scheduler.sv
// tb_frame_reply_scheduler: vector table plus directed sequences for the reply scheduler.
module tb_frame_reply_scheduler;
  localparam int TO = 20;
  logic        clk = 1'b0, rst = 1'b1;
  logic        err_req = 1'b0, cmp_req = 1'b0, bld_done = 1'b0;
  logic [7:0]  err_status = '0, err_cmd = '0, cmp_status = '0, cmp_cmd = '0;
  logic        err_ack, cmp_ack, bld_start, sched_idle, timeout_err;
  logic [7:0]  bld_status, bld_cmd, drop_count;
  logic [15:0] crc_err_count, reply_count;
  int          checks = 0, failures = 0;
  int          dly = 0, cmp_acks = 0, err_acks = 0;
  logic        auto_bld = 1'b0;
  logic [15:0] launches [$];
  logic [15:0] pend_q [$];
  logic [15:0] exp_q [$];
  typedef struct {
    logic [34:0] stim;
    logic [19:0] exp;
  } vec_t;
  vec_t tbl [$];

  frame_reply_scheduler #(.ERR_QUEUE_DEPTH(4), .TIMEOUT_CYCLES(TO), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .err_req(err_req), .err_status(err_status), .err_cmd(err_cmd), .err_ack(err_ack),
    .cmp_req(cmp_req), .cmp_status(cmp_status), .cmp_cmd(cmp_cmd), .cmp_ack(cmp_ack),
    .bld_start(bld_start), .bld_status(bld_status), .bld_cmd(bld_cmd), .bld_done(bld_done),
    .sched_idle(sched_idle), .drop_count(drop_count), .timeout_err(timeout_err),
    .crc_err_count(crc_err_count), .reply_count(reply_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic er, input logic [7:0] es, input logic [7:0] ec,
                              input logic cr, input logic [7:0] cs, input logic [7:0] cc, input logic bd,
                              input logic ea, input logic bs, input logic [7:0] st, input logic [7:0] cm,
                              input logic ca, input logic si);
    vec_t v;
    v.stim = {er, es, ec, cr, cs, cc, bd};
    v.exp  = {ea, bs, st, cm, ca, si};
    return v;
  endfunction

  // Advance one clock, sample #1 after the edge, and model a builder that answers 2 cycles after bld_start.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bld_start) begin
      launches.push_back({bld_status, bld_cmd});
      dly = 3;
    end else if (dly > 0) dly--;
    if (err_ack) err_acks++;
    if (cmp_ack) begin
      cmp_acks++;
      cmp_req = 1'b0;
    end
    bld_done = auto_bld && dly == 1;
  endtask

  task automatic do_reset();
    {err_req, cmp_req, bld_done} = 3'b000;
    {err_status, err_cmd, cmp_status, cmp_cmd} = '0;
    rst = 1'b1;
    auto_bld = 1'b0;
    dly = 0;
    cmp_acks = 0;
    err_acks = 0;
    launches.delete();
    pend_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_err(input logic [7:0] s, input logic [7:0] c);
    err_req = 1'b1;
    err_status = s;
    err_cmd = c;
    tick();
    err_req = 1'b0;
  endtask

  // Pending errors are injected on bld_done cycles, i.e. exactly when a pop frees a slot.
  task automatic run(input string nm, input int max_cyc);
    int n = 0;
    while (n < max_cyc) begin
      if (bld_done && pend_q.size() > 0) begin
        err_req = 1'b1;
        {err_status, err_cmd} = pend_q.pop_front();
      end
      tick();
      err_req = 1'b0;
      n++;
      if (sched_idle && !cmp_req && pend_q.size() == 0 && dly == 0) break;
    end
    chk({nm, "_bound"}, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic chk_launches(input string nm);
    chk({nm, "_launch_count"}, 32'(launches.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < launches.size(); i++)
      chk($sformatf("%s_launch%0d", nm, i), 32'(launches[i]), 32'(exp_q[i]));
  endtask

  initial begin
    tbl.push_back(mk(1'b1,8'h01,8'hA5,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,8'h00,8'h00,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b1,8'h01,8'hA5,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b1, 1'b0,1'b0,8'h01,8'hA5,1'b0,1'b0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,8'h01,8'hA5,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b1, 1'b0,1'b0,8'h01,8'hA5,1'b0,1'b1));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b1,8'h00,8'h3C,1'b0, 1'b0,1'b1,8'h00,8'h3C,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b1,8'h00,8'h3C,1'b0, 1'b0,1'b0,8'h00,8'h3C,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b1,8'h00,8'h3C,1'b1, 1'b0,1'b0,8'h00,8'h3C,1'b1,1'b1));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b1,8'h00,8'h3C,1'b0, 1'b0,1'b0,8'h00,8'h3C,1'b0,1'b1));
    tbl.push_back(mk(1'b1,8'h02,8'h11,1'b0,8'h00,8'h00,1'b0, 1'b1,1'b0,8'h00,8'h3C,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b1,8'h00,8'h77,1'b0, 1'b0,1'b1,8'h02,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,8'h02,8'h11,1'b0,1'b0));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b1, 1'b0,1'b0,8'h02,8'h11,1'b0,1'b1));
    tbl.push_back(mk(1'b0,8'h00,8'h00,1'b0,8'h00,8'h00,1'b0, 1'b0,1'b0,8'h02,8'h11,1'b0,1'b1));

    do_reset();
    chk("reset_outputs", 32'({err_ack, cmp_ack, bld_start, bld_status, bld_cmd, sched_idle, drop_count, timeout_err}),
        32'({1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0}));
    chk("reset_stats", 32'({crc_err_count, reply_count}), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      {err_req, err_status, err_cmd, cmp_req, cmp_status, cmp_cmd, bld_done} = tbl[i].stim;
      tick();
      chk($sformatf("vec%0d", i), 32'({err_ack, bld_start, bld_status, bld_cmd, cmp_ack, sched_idle}), 32'(tbl[i].exp));
    end

    // Overflow: five back-to-back pushes into a depth-4 queue with a stalled builder.
    do_reset();
    for (int i = 0; i < 5; i++) push_err(8'h10 + 8'(i), 8'h80 + 8'(i));
    chk("ovf_err_acks", 32'(err_acks), 32'd4);
    chk("ovf_drop_count", 32'(drop_count), 32'd1);
    auto_bld = 1'b1;
    run("ovf", 200);
    exp_q = {16'h1080, 16'h1181, 16'h1282, 16'h1383};
    chk_launches("ovf");
    chk("ovf_drop_after", 32'(drop_count), 32'd1);

    // Starvation: completion held while errors keep arriving.
    do_reset();
    auto_bld = 1'b1;
    pend_q = {16'h24E4, 16'h25E5};
    push_err(8'h20, 8'hE0);
    cmp_req = 1'b1;
    cmp_status = 8'h00;
    cmp_cmd = 8'hC0;
    push_err(8'h21, 8'hE1);
    push_err(8'h22, 8'hE2);
    push_err(8'h23, 8'hE3);
    run("starve", 300);
    exp_q = {16'h20E0, 16'h21E1, 16'h22E2, 16'h23E3, 16'h00C0, 16'h24E4, 16'h25E5};
    chk_launches("starve");
    chk("starve_cmp_acks", 32'(cmp_acks), 32'd1);
    chk("starve_err_acks", 32'(err_acks), 32'd6);
    chk("starve_no_drop", 32'(drop_count), 32'd0);

    // Watchdog: first launch never completes.
    do_reset();
    push_err(8'h31, 8'hC1);
    push_err(8'h32, 8'hC2);
    chk("to_first_start", 32'(bld_start), 32'd1);
    repeat (TO) tick();
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    chk("to_flag", 32'(timeout_err), 32'd1);
    tick();
    chk("to_next_start", 32'({bld_start, bld_status, bld_cmd}), 32'({1'b1, 8'h32, 8'hC2}));
    auto_bld = 1'b1;
    run("to", 100);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_launch_count", 32'(launches.size()), 32'd2);

    // Asynchronous reset while waiting for bld_done with three queued entries.
    do_reset();
    push_err(8'h41, 8'hB1);
    push_err(8'h42, 8'hB2);
    push_err(8'h43, 8'hB3);
    tick();
    chk("rst_busy", 32'(sched_idle), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'({sched_idle, bld_start, err_ack, cmp_ack, bld_status, bld_cmd}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
    launches.delete();
    err_acks = 0;
    cmp_acks = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bld_done = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("rst_no_launch", 32'(launches.size()), 32'd0);
    chk("rst_no_ack", 32'(err_acks + cmp_acks), 32'd0);
    chk("rst_idle", 32'(sched_idle), 32'd1);

    // Statistics: replies 0x01, 0x00, 0x01.
    do_reset();
    auto_bld = 1'b1;
    push_err(8'h01, 8'hD1);
    run("stat_a", 50);
    cmp_req = 1'b1;
    cmp_status = 8'h00;
    cmp_cmd = 8'hD2;
    run("stat_b", 50);
    push_err(8'h01, 8'hD3);
    run("stat_c", 50);
    exp_q = {16'h01D1, 16'h00D2, 16'h01D3};
    chk_launches("stat");
`ifdef REPLY_STATS_EN
    chk("stat_crc", 32'(crc_err_count), 32'd2);
    chk("stat_reply", 32'(reply_count), 32'd3);
`else
    chk("stat_crc", 32'(crc_err_count), 32'd0);
    chk("stat_reply", 32'(reply_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
